// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // state      | meaning
  // PS2_IDLE   | waiting for a start bit on a filtered PS/2 clock fall
  // PS2_RECV   | collecting data, parity and stop bits of one frame
  typedef enum logic {
    PS2_IDLE = 1'b0,
    PS2_RECV = 1'b1
  } ps2_state_e;

  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_PAR_IDX   = 8;
  localparam int PS2_STOP_IDX  = 9;
  localparam int PS2_BITCNT_W  = 4;

endpackage

// File: rtl/ps2_fifo.sv
// Show-ahead FIFO holding received scan-code bytes.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PS2_DATA_BITS-1:0] din,
  output logic [PS2_DATA_BITS-1:0] dout,
  output logic                     empty,
  output logic                     full
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr_q;
  logic [FIFO_AW-1:0]       rd_ptr_q;
  logic [FIFO_AW:0]         count_q;
  logic                     do_push;
  logic                     do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  // Gating the head to zero when empty gives a defined key_data after reset without clearing the array.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: input conditioning, frame FSM and byte FIFO for the CPU.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW    = 3,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       io_rdn,
  output logic [7:0] key_data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [FCNT_W-1:0]       FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]        TMO_LOAD  = TMO_W'(TIMEOUT - 1);
  localparam logic [PS2_BITCNT_W-1:0] PAR_CNT   = PS2_BITCNT_W'(PS2_PAR_IDX);
  localparam logic [PS2_BITCNT_W-1:0] STOP_CNT  = PS2_BITCNT_W'(PS2_STOP_IDX);

  logic                     clk_s1_q, clk_s2_q;
  logic                     dat_s1_q, dat_s2_q;
  logic                     fclk_q, fclk_prev_q;
  logic [FCNT_W-1:0]        fcnt_q;
  logic                     fall;

  ps2_state_e               state_q, state_d;
  logic [PS2_BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     par_q, par_d;
  logic                     par_ok_q, par_ok_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     push_q, push_d;
  logic                     ferr_q, ferr_d;

  logic                     rdn_q;
  logic                     pop;
  logic                     overflow_q;
  logic                     fifo_empty, fifo_full;

  // Two-stage synchronizers; preset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: fclk follows the pin only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      fclk_prev_q <= fclk_q;
      if (clk_s2_q != fclk_q) begin
        if (fcnt_q == FCNT_LAST) begin
          fclk_q <= clk_s2_q;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  assign fall = fclk_prev_q & ~fclk_q;

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PS2_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      par_ok_q <= 1'b0;
      tmo_q    <= '0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      par_ok_q <= par_ok_d;
      tmo_q    <= tmo_d;
      push_q   <= push_d;
      ferr_q   <= ferr_d;
    end
  end

  // Frame FSM next state: bit collection, parity/stop validation and mid-frame timeout.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    par_ok_d = par_ok_q;
    tmo_d    = tmo_q;
    push_d   = 1'b0;
    ferr_d   = 1'b0;

    // Down-counter restarts on every fall; reaching zero in RECV means the keyboard stalled.
    if (fall) begin
      tmo_d = TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
    end

    case (state_q)
      PS2_IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d  = PS2_RECV;
          bitcnt_d = '0;
          par_d    = 1'b0;
        end
      end
      PS2_RECV: begin
        if (fall) begin
          if (bitcnt_q < PAR_CNT) begin
            shreg_d  = {dat_s2_q, shreg_q[PS2_DATA_BITS-1:1]};
            par_d    = par_q ^ dat_s2_q;
            bitcnt_d = bitcnt_q + 1'b1;
          end else if (bitcnt_q == PAR_CNT) begin
            par_ok_d = par_q ^ dat_s2_q;
            bitcnt_d = bitcnt_q + 1'b1;
          end else if (bitcnt_q == STOP_CNT) begin
            state_d = PS2_IDLE;
            if (dat_s2_q && par_ok_q) push_d = 1'b1;
            else                      ferr_d = 1'b1;
          end else begin
            state_d = PS2_IDLE;
          end
        end else if (tmo_q == '0) begin
          state_d = PS2_IDLE;
          ferr_d  = 1'b1;
        end
      end
      default: state_d = PS2_IDLE;
    endcase
  end

  // Read-strobe edge detect and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rdn_q <= io_rdn;
      if (push_q && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign pop = rdn_q & ~io_rdn & ~fifo_empty;

  ps2_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop),
    .din   (shreg_q),
    .dout  (key_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ready     = ~fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx against a queue-based reference model.
module tb_ps2_kbd_rx;

  localparam int FL     = 4;
  localparam int TMO    = 200;
  localparam int HP     = 20;
  localparam int AW     = 3;
  localparam int DEPTH  = 1 << AW;
  localparam int PUSH_K = 2 + FL + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       io_rdn = 1'b1;
  logic [7:0] key_data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_kbd_rx #(
    .FIFO_AW    (AW),
    .FILTER_LEN (FL),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .io_rdn    (io_rdn),
    .key_data  (key_data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ferr_cyc = 0;
  int fall_cyc = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_ferr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      ferr_cnt = ferr_cnt + 1;
      ferr_cyc = cyc;
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Drive nbits of a frame LSB first; optionally time an io_rdn fall onto the push cycle.
  task automatic send_raw(input logic [10:0] bits, input int nbits, input bit pop_at_push);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      for (int k = 1; k <= HP; k++) begin
        @(negedge clk);
        if (pop_at_push && i == nbits - 1) begin
          if (k == PUSH_K)     io_rdn = 1'b0;
          if (k == PUSH_K + 3) io_rdn = 1'b1;
        end
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic par, input logic stop, input bit pop_at_push);
    bit valid;
    valid = (((^d) ^ par) == 1'b1) && (stop == 1'b1);
    send_raw(frame_bits(d, par, stop), 11, pop_at_push);
    if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
    if (!valid)                  m_ferr++;
    else if (mq.size() < DEPTH)  mq.push_back(d);
    else                         m_ovf = 1'b1;
  endtask

  task automatic do_pop();
    @(negedge clk);
    io_rdn = 1'b0;
    repeat (3) @(negedge clk);
    io_rdn = 1'b1;
    repeat (2) @(negedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ready !== 1'b0)      begin n_errors++; $display("FAIL reset_ready got %b want 0", ready); end
    n_checks++; if (key_data !== 8'h00)  begin n_errors++; $display("FAIL reset_key got %h want 00", key_data); end
    n_checks++; if (overflow !== 1'b0)   begin n_errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_checks++; if (frame_err !== 1'b0)  begin n_errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int f0;
    f0 = ferr_cnt;
    send_byte(8'h1C, 1'b0, 1'b1, 1'b0);
    send_byte(8'h2B, ~^8'h2B, 1'b1, 1'b0);
    n_checks++; if (ready !== 1'b1)      begin n_errors++; $display("FAIL single_ready got %b want 1", ready); end
    n_checks++; if (key_data !== mq[0])  begin n_errors++; $display("FAIL single_key got %h want %h", key_data, mq[0]); end
    n_checks++; if (ferr_cnt != f0)      begin n_errors++; $display("FAIL single_ferr got %0d want %0d", ferr_cnt - f0, 0); end
    do_pop();
    n_checks++; if (key_data !== mq[0])  begin n_errors++; $display("FAIL single_onepop_key got %h want %h", key_data, mq[0]); end
    do_pop();
    n_checks++; if (ready !== 1'b0)      begin n_errors++; $display("FAIL single_empty got %b want 0", ready); end
  endtask

  task automatic test_bad_parity();
    send_byte(8'h1C, 1'b1, 1'b1, 1'b0);
    n_checks++; if (ferr_cnt != m_ferr)  begin n_errors++; $display("FAIL badpar_ferr got %0d want %0d", ferr_cnt, m_ferr); end
    n_checks++; if (ready !== 1'b0)      begin n_errors++; $display("FAIL badpar_ready got %b want 0", ready); end
    send_byte(8'hF0, ~^8'hF0, 1'b1, 1'b0);
    n_checks++; if (key_data !== 8'hF0)  begin n_errors++; $display("FAIL badpar_next_key got %h want f0", key_data); end
    do_pop();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_byte(8'(i), ~^(8'(i)), 1'b1, 1'b0);
    n_checks++; if (overflow !== m_ovf)  begin n_errors++; $display("FAIL ovf_flag got %b want %b", overflow, m_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (key_data !== mq[0]) begin n_errors++; $display("FAIL ovf_read%0d got %h want %h", i, key_data, mq[0]); end
      do_pop();
    end
    n_checks++; if (ready !== 1'b0)      begin n_errors++; $display("FAIL ovf_drained got %b want 0", ready); end
  endtask

  task automatic test_full_pop();
    pulse_rst();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), ~^(8'(i)), 1'b1, 1'b0);
    send_byte(8'h09, ~^8'h09, 1'b1, 1'b1);
    n_checks++; if (overflow !== m_ovf)  begin n_errors++; $display("FAIL fullpop_ovf got %b want %b", overflow, m_ovf); end
    n_checks++; if (mq.size() != DEPTH)  begin n_errors++; $display("FAIL fullpop_model got %0d want %0d", mq.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (key_data !== mq[0]) begin n_errors++; $display("FAIL fullpop_read%0d got %h want %h", i, key_data, mq[0]); end
      do_pop();
    end
    n_checks++; if (ready !== 1'b0)      begin n_errors++; $display("FAIL fullpop_drained got %b want 0", ready); end
  endtask

  task automatic test_timeout();
    int  f0, dt;
    bit  seen;
    f0 = ferr_cnt;
    send_raw(frame_bits(8'hA5, 1'b0, 1'b1), 5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ferr_cnt != f0) seen = 1'b1;
    end
    dt = ferr_cyc - fall_cyc;
    n_checks++; if (!seen) begin n_errors++; $display("FAIL tmo_seen got none want pulse within 400 cycles"); end
    n_checks++; if (dt < TMO + 2 + FL - 1 || dt > TMO + 2 + FL + 2)
      begin n_errors++; $display("FAIL tmo_delay got %0d want %0d..%0d", dt, TMO + 2 + FL - 1, TMO + 2 + FL + 2); end
    repeat (5) @(negedge clk);
    m_ferr++;
    n_checks++; if (ferr_cnt != f0 + 1)  begin n_errors++; $display("FAIL tmo_pulse_len got %0d want 1", ferr_cnt - f0); end
    send_byte(8'h5A, ~^8'h5A, 1'b1, 1'b0);
    n_checks++; if (key_data !== 8'h5A || ready !== 1'b1)
      begin n_errors++; $display("FAIL tmo_next got %h/%b want 5a/1", key_data, ready); end
    n_checks++; if (ferr_cnt != m_ferr)  begin n_errors++; $display("FAIL tmo_ferr_total got %0d want %0d", ferr_cnt, m_ferr); end
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = ferr_cnt;
    send_raw(frame_bits(8'h33, 1'b1, 1'b1), 5, 1'b0);
    pulse_rst();
    send_byte(8'h29, 1'b0, 1'b1, 1'b0);
    n_checks++; if (key_data !== 8'h29)  begin n_errors++; $display("FAIL rstmid_key got %h want 29", key_data); end
    n_checks++; if (ready !== 1'b1)      begin n_errors++; $display("FAIL rstmid_ready got %b want 1", ready); end
    n_checks++; if (overflow !== 1'b0)   begin n_errors++; $display("FAIL rstmid_ovf got %b want 0", overflow); end
    n_checks++; if (ferr_cnt != f0)      begin n_errors++; $display("FAIL rstmid_ferr got %0d want 0", ferr_cnt - f0); end
    do_pop();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       par, stop;
    pulse_rst();
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      par  = ($urandom_range(0, 3) != 0) ? ~^d : ^d;
      stop = ($urandom_range(0, 5) != 0);
      send_byte(d, par, stop, 1'b0);
      if ($urandom_range(0, 1) == 1) do_pop();
      n_checks++; if (ready !== (mq.size() != 0)) begin n_errors++; $display("FAIL rand%0d_ready got %b want %b", n, ready, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++; if (key_data !== mq[0]) begin n_errors++; $display("FAIL rand%0d_key got %h want %h", n, key_data, mq[0]); end
      end
      n_checks++; if (overflow !== m_ovf)   begin n_errors++; $display("FAIL rand%0d_ovf got %b want %b", n, overflow, m_ovf); end
      n_checks++; if (ferr_cnt != m_ferr)   begin n_errors++; $display("FAIL rand%0d_ferr got %0d want %0d", n, ferr_cnt, m_ferr); end
    end
    while (mq.size() != 0) begin
      n_checks++; if (key_data !== mq[0]) begin n_errors++; $display("FAIL rand_drain got %h want %h", key_data, mq[0]); end
      do_pop();
    end
    n_checks++; if (ready !== 1'b0)       begin n_errors++; $display("FAIL rand_drained got %b want 0", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_parity();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
